// File: rtl/led_pwm_controller.sv
// Memory-mapped LED controller: per-channel PWM dimming, prescaler, readback.
// Optional blink logic is built only when LED_CONTROLLER_BLINK_EN is defined.
module led_pwm_controller #(
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0000,
    parameter int          CHANNELS     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         addressBus,
    input  logic [7:0]          dataBusIn,
    input  logic                readRequest,
    input  logic                mio,
    input  logic                enable,
    output logic [7:0]          dataBusOut,
    output logic [CHANNELS-1:0] ledState
);

    localparam int          NUM_REGS    = 4 + CHANNELS;
    localparam logic [31:0] LAST_OFFSET = 32'(NUM_REGS - 1);

    localparam logic [3:0] OFF_CTRL     = 4'd0;
    localparam logic [3:0] OFF_STATE    = 4'd1;
    localparam logic [3:0] OFF_PRESCALE = 4'd2;
    localparam logic [3:0] OFF_BLINK    = 4'd3;

    // Bus cycle: a transfer happens on any rising edge where enable is high and
    // mio is low; there are no wait states and no acknowledge.
    logic [31:0] w_offset;
    logic [3:0]  w_reg_sel;
    logic        w_hit;
    logic        w_wr_hit;
    logic        w_rd_hit;
    logic        w_wr_ctrl;
    logic        w_wr_state;
    logic        w_wr_prescale;

    assign w_offset      = addressBus - BASE_ADDRESS;
    assign w_reg_sel     = w_offset[3:0];
    assign w_hit         = enable && !mio && (w_offset <= LAST_OFFSET);
    assign w_wr_hit      = w_hit && !readRequest;
    assign w_rd_hit      = w_hit && readRequest;
    assign w_wr_ctrl     = w_wr_hit && (w_reg_sel == OFF_CTRL);
    assign w_wr_state    = w_wr_hit && (w_reg_sel == OFF_STATE);
    assign w_wr_prescale = w_wr_hit && (w_reg_sel == OFF_PRESCALE);

    logic [1:0]          r_ctrl;
    logic [CHANNELS-1:0] r_state;
    logic [7:0]          r_prescale;
    logic [7:0]          r_pre_count;
    logic [7:0]          r_pwm_count;
    logic [7:0]          r_duty_shadow [CHANNELS];
    logic [7:0]          r_duty_active [CHANNELS];
    logic [7:0]          r_data_out;
    logic [CHANNELS-1:0] r_led;

    logic w_tick;
    logic w_frame_end;

    assign w_tick      = (r_pre_count == r_prescale);
    assign w_frame_end = w_tick && (r_pwm_count == 8'hFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ctrl     <= '0;
            r_state    <= '0;
            r_prescale <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= dataBusIn[1:0];
            end
            if (w_wr_state) begin
                r_state <= dataBusIn[CHANNELS-1:0];
            end
            if (w_wr_prescale) begin
                r_prescale <= dataBusIn;
            end
        end
    end

    // A PRESCALE write restarts the divider, but a tick due on that edge still fires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre_count <= '0;
            r_pwm_count <= '0;
        end else begin
            if (w_wr_prescale || w_tick) begin
                r_pre_count <= '0;
            end else begin
                r_pre_count <= r_pre_count + 8'd1;
            end
            if (w_tick) begin
                r_pwm_count <= r_pwm_count + 8'd1;
            end
        end
    end

    // Duty is double-buffered so a frame never sees a mid-frame duty change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_shadow[i] <= '0;
                r_duty_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_hit && (w_reg_sel == 4'(4 + i))) begin
                    r_duty_shadow[i] <= dataBusIn;
                end
                if (w_frame_end) begin
                    r_duty_active[i] <= r_duty_shadow[i];
                end
            end
        end
    end

    logic       w_blink_phase;
    logic [7:0] w_blink_rd;

`ifdef LED_CONTROLLER_BLINK_EN
    logic       w_wr_blink;
    logic [7:0] r_blink;
    logic [7:0] r_frame_count;
    logic       r_blink_phase;

    assign w_wr_blink = w_wr_hit && (w_reg_sel == OFF_BLINK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink       <= '0;
            r_frame_count <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wr_blink) begin
            r_blink       <= dataBusIn;
            r_frame_count <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink == 8'd0) begin
            r_frame_count <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (r_frame_count == (r_blink - 8'd1)) begin
                r_frame_count <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign w_blink_phase = r_blink_phase;
    assign w_blink_rd    = r_blink;
`else
    assign w_blink_phase = 1'b1;
    assign w_blink_rd    = 8'h00;
`endif

    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_reg_sel)
            OFF_CTRL:     w_rd_data[1:0]          = r_ctrl;
            OFF_STATE:    w_rd_data[CHANNELS-1:0] = r_state;
            OFF_PRESCALE: w_rd_data               = r_prescale;
            OFF_BLINK:    w_rd_data               = w_blink_rd;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_reg_sel == 4'(4 + i)) begin
                        w_rd_data = r_duty_shadow[i];
                    end
                end
            end
        endcase
    end

    logic [CHANNELS-1:0] w_led_next;

    always_comb begin
        w_led_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_led_next[i] = r_ctrl[0] & r_state[i] & w_blink_phase &
                            (r_ctrl[1] ? (r_pwm_count < r_duty_active[i]) : 1'b1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data_out <= 8'h00;
            r_led      <= '0;
        end else begin
            if (w_rd_hit) begin
                r_data_out <= w_rd_data;
            end
            r_led <= w_led_next;
        end
    end

    assign dataBusOut = r_data_out;
    assign ledState   = r_led;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Self-checking bench for led_pwm_controller: register model, PWM duty arithmetic, blink timing.
module tb_led_pwm_controller;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CH    = 8;
  localparam int          NREGS = 4 + CH;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   addressBus = '0;
  logic [7:0]    dataBusIn = '0;
  logic          readRequest = 1'b0;
  logic          mio = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    dataBusOut;
  logic [CH-1:0] ledState;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_regs [NREGS];
  logic [7:0] exp_q [$];

  led_pwm_controller #(.BASE_ADDRESS(BASE), .CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .dataBusIn(dataBusIn),
    .readRequest(readRequest), .mio(mio), .enable(enable),
    .dataBusOut(dataBusOut), .ledState(ledState)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [7:0] reg_mask(input int off);
    case (off)
      0: return 8'h03;
      1: return 8'((1 << CH) - 1);
`ifdef LED_CONTROLLER_BLINK_EN
      3: return 8'hFF;
`else
      3: return 8'h00;
`endif
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
  endtask

  // driver tasks: start and end on a falling edge
  task automatic bus_write_addr(input logic [31:0] a, input logic [7:0] d, input logic m);
    logic [31:0] off;
    @(negedge clock);
    enable = 1'b1; readRequest = 1'b0; mio = m; addressBus = a; dataBusIn = d;
    @(negedge clock);
    enable = 1'b0; mio = 1'b0;
    off = a - BASE;
    if (!m && off < 32'(NREGS)) exp_regs[off] = d & reg_mask(int'(off));
  endtask

  task automatic bus_write(input int off, input logic [7:0] d);
    bus_write_addr(BASE + 32'(off), d, 1'b0);
  endtask

  task automatic bus_read_addr(input logic [31:0] a, input logic m, output logic [7:0] d);
    @(negedge clock);
    enable = 1'b1; readRequest = 1'b1; mio = m; addressBus = a;
    @(negedge clock);
    enable = 1'b0; readRequest = 1'b0; mio = 1'b0;
    d = dataBusOut;
  endtask

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // counts high samples of one LED over a window of n clocks
  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (ledState[ch] === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    reset = 1'b0;
    wait_clocks(3);
    reset = 1'b1;
    model_reset();
    checks++;
    if (ledState !== '0) $display("FAIL reset_led: got %0h expected 0", ledState);
    else passed++;
    checks++;
    if (dataBusOut !== 8'h00) $display("FAIL reset_dout: got %0h expected 0", dataBusOut);
    else passed++;
    for (int i = 0; i < NREGS; i++) begin
      bus_read_addr(BASE + 32'(i), 1'b0, rd);
      checks++;
      if (rd !== 8'h00) $display("FAIL reset_reg%0d: got %0h expected 0", i, rd);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rd;
    bus_write(0, 8'h01);
    bus_write(1, 8'hFF);
    wait_clocks(1);
    checks++;
    if (ledState !== 8'hFF) $display("FAIL midrst_pre: got %0h expected ff", ledState);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ledState !== '0) $display("FAIL midrst_async: got %0h expected 0", ledState);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    bus_read_addr(BASE + 32'd1, 1'b0, rd);
    checks++;
    if (rd !== 8'h00) $display("FAIL midrst_state: got %0h expected 0", rd);
    else passed++;
  endtask

  task automatic test_onoff();
    logic [7:0] s;
    bus_write(0, 8'h01);
    bus_write(1, 8'hA5);
    checks++;
    if (ledState !== 8'h00) $display("FAIL onoff_early: got %0h expected 0", ledState);
    else passed++;
    @(negedge clock);
    checks++;
    if (ledState !== 8'hA5) $display("FAIL onoff_a5: got %0h expected a5", ledState);
    else passed++;
    bus_write_addr(BASE + 32'd1, 8'h3C, 1'b1);
    wait_clocks(2);
    checks++;
    if (ledState !== 8'hA5) $display("FAIL onoff_mio: got %0h expected a5", ledState);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      s = 8'($urandom_range(0, 255));
      bus_write(1, s);
      @(negedge clock);
      checks++;
      if (ledState !== s) $display("FAIL onoff_rand%0d: got %0h expected %0h", k, ledState, s);
      else passed++;
    end
    bus_write(0, 8'h00);
    @(negedge clock);
    checks++;
    if (ledState !== 8'h00) $display("FAIL onoff_disable: got %0h expected 0", ledState);
    else passed++;
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    bus_write(0, 8'h01);
    bus_write(1, 8'h5A);
    bus_write_addr(BASE - 32'd1, 8'h00, 1'b0);
    bus_write_addr(BASE + 32'(NREGS), 8'h00, 1'b0);
    bus_write_addr(BASE + 32'h10, 8'h00, 1'b0);
    bus_write_addr(BASE + 32'h10001, 8'h00, 1'b0);
    wait_clocks(1);
    checks++;
    if (ledState !== 8'h5A) $display("FAIL oor_led: got %0h expected 5a", ledState);
    else passed++;
    bus_read_addr(BASE + 32'd1, 1'b0, rd);
    bus_read_addr(BASE + 32'(NREGS), 1'b0, rd);
    checks++;
    if (rd !== 8'h5A) $display("FAIL oor_readmiss_hi: got %0h expected 5a", rd);
    else passed++;
    bus_read_addr(BASE - 32'd1, 1'b0, rd);
    bus_read_addr(BASE, 1'b1, rd);
    checks++;
    if (rd !== 8'h5A) $display("FAIL oor_readmiss_mio: got %0h expected 5a", rd);
    else passed++;
  endtask

  // scoreboard: random writes, random reads checked through exp_q
  task automatic test_registers();
    logic [7:0] rd;
    logic [7:0] ex;
    int off;
    for (int k = 0; k < 20; k++) begin
      off = $urandom_range(0, NREGS - 1);
      bus_write(off, 8'($urandom_range(0, 255)));
      off = $urandom_range(0, NREGS - 1);
      exp_q.push_back(exp_regs[off]);
      bus_read_addr(BASE + 32'(off), 1'b0, rd);
      ex = exp_q.pop_front();
      checks++;
      if (rd !== ex) $display("FAIL reg_rand%0d off%0d: got %0h expected %0h", k, off, rd, ex);
      else passed++;
    end
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back(exp_regs[i]);
      bus_read_addr(BASE + 32'(i), 1'b0, rd);
      ex = exp_q.pop_front();
      checks++;
      if (rd !== ex) $display("FAIL reg_all%0d: got %0h expected %0h", i, rd, ex);
      else passed++;
    end
  endtask

  task automatic test_pwm();
    int hi;
    bus_write(3, 8'h00);
    bus_write(0, 8'h03);
    bus_write(1, 8'h01);
    bus_write(2, 8'h00);
    bus_write(4, 8'd64);
    wait_clocks(256 + 4);
    count_high(0, 256, hi);
    checks++;
    if (hi !== 64) $display("FAIL pwm_duty64: got %0d high clocks expected 64", hi);
    else passed++;
  endtask

  task automatic test_duty_update();
    logic prev;
    logic found;
    int hi_a;
    int hi_b;
    found = 1'b0;
    prev = ledState[0];
    for (int k = 0; k < 1024 && !found; k++) begin
      @(negedge clock);
      if (prev === 1'b0 && ledState[0] === 1'b1) found = 1'b1;
      prev = ledState[0];
    end
    checks++;
    if (!found) begin
      $display("FAIL duty_upd_rise: got no rising edge expected one within 1024 clocks");
      return;
    end
    passed++;
    hi_a = 1;
    hi_b = 0;
    for (int n = 1; n < 512; n++) begin
      @(negedge clock);
      if (ledState[0] === 1'b1) begin
        if (n < 256) hi_a++;
        else hi_b++;
      end
      if (n == 102) begin
        checks++;
        if (dataBusOut !== 8'd200) $display("FAIL duty_upd_readback: got %0d expected 200", dataBusOut);
        else passed++;
      end
      if (n == 100) begin
        enable = 1'b1; readRequest = 1'b0; addressBus = BASE + 32'd4; dataBusIn = 8'd200;
      end else if (n == 101) begin
        readRequest = 1'b1;
      end else if (n == 102) begin
        enable = 1'b0; readRequest = 1'b0;
      end
    end
    exp_regs[4] = 8'd200;
    checks++;
    if (hi_a !== 64) $display("FAIL duty_upd_old: got %0d high clocks expected 64", hi_a);
    else passed++;
    checks++;
    if (hi_b !== 200) $display("FAIL duty_upd_new: got %0d high clocks expected 200", hi_b);
    else passed++;
  endtask

  task automatic test_prescale();
    int hi;
    bus_write(2, 8'd3);
    bus_write(4, 8'd128);
    wait_clocks(1024 + 4);
    count_high(0, 1024, hi);
    checks++;
    if (hi !== 512) $display("FAIL prescale3: got %0d high clocks expected 512", hi);
    else passed++;
  endtask

  task automatic test_pwm_random();
    int hi;
    int p;
    int duty;
    int ch;
    int frame;
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(0, 2);
      ch = $urandom_range(0, CH - 1);
      duty = (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(0, 255);
      frame = 256 * (p + 1);
      bus_write(1, 8'(1 << ch));
      bus_write(2, 8'(p));
      bus_write(4 + ch, 8'(duty));
      wait_clocks(frame + 4);
      count_high(ch, frame, hi);
      checks++;
      if (hi !== duty * (p + 1))
        $display("FAIL pwm_rand%0d ch%0d p%0d duty%0d: got %0d expected %0d", k, ch, p, duty, hi, duty * (p + 1));
      else passed++;
    end
  endtask

  task automatic test_blink();
    int hi;
    logic [7:0] rd;
    bus_write(0, 8'h01);
    bus_write(1, 8'h01);
    bus_write(2, 8'h00);
    bus_write(3, 8'd2);
`ifdef LED_CONTROLLER_BLINK_EN
    begin
      logic prev;
      logic found;
      found = 1'b0;
      prev = ledState[0];
      for (int k = 0; k < 2048 && !found; k++) begin
        @(negedge clock);
        if (prev === 1'b1 && ledState[0] === 1'b0) found = 1'b1;
        prev = ledState[0];
      end
      checks++;
      if (!found) begin
        $display("FAIL blink_fall: got no falling edge expected one within 2048 clocks");
        return;
      end
      passed++;
      count_high(0, 511, hi);
      checks++;
      if (hi !== 0) $display("FAIL blink_off: got %0d high clocks expected 0", hi);
      else passed++;
      count_high(0, 512, hi);
      checks++;
      if (hi !== 512) $display("FAIL blink_on: got %0d high clocks expected 512", hi);
      else passed++;
      count_high(0, 1, hi);
      checks++;
      if (hi !== 0) $display("FAIL blink_off2: got %0d high clocks expected 0", hi);
      else passed++;
      bus_read_addr(BASE + 32'd3, 1'b0, rd);
      checks++;
      if (rd !== 8'd2) $display("FAIL blink_read: got %0h expected 02", rd);
      else passed++;
    end
`else
    count_high(0, 1024, hi);
    checks++;
    if (hi !== 1024) $display("FAIL blink_absent_on: got %0d high clocks expected 1024", hi);
    else passed++;
    bus_read_addr(BASE + 32'd3, 1'b0, rd);
    checks++;
    if (rd !== exp_regs[3]) $display("FAIL blink_absent_read: got %0h expected %0h", rd, exp_regs[3]);
    else passed++;
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_midframe();
    test_onoff();
    test_out_of_range();
    test_registers();
    test_pwm();
    test_duty_update();
    test_prescale();
    test_pwm_random();
    test_blink();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
